adc_scan_hyst: RTL

//  Multi-channel successor to the single-channel ADC capture + hysteresis pair. Drives an
//  ADC128S022-style 8-input 12-bit SPI ADC and round-robins over the channels enabled in
//  ch_mask. Applies per-channel hysteresis thresholds and publishes every sample on a 1-cycle

---
 rtl/adc_scan_hyst.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/adc_scan_hyst.sv
// Round-robin scanner for an 8-input 12-bit SPI ADC with per-channel hysteresis flags.
// Each frame addresses the next enabled channel and returns the channel addressed in the frame before.
module adc_scan_hyst #(
  parameter int CLK_HZ      = 25000000,
  parameter int SCLK_HZ     = 5000000,
  parameter int N_CH        = 4,
  parameter int CYCLE_PAUSE = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [N_CH*12-1:0] th_high,
  input  logic [N_CH*12-1:0] th_low,
  input  logic               spi_miso,
  output logic               spi_mosi,
  output logic               spi_sclk,
  output logic               spi_csn,
  output logic               sample_valid,
  output logic [2:0]         sample_ch,
  output logic [11:0]        sample_data,
  output logic [N_CH*12-1:0] data_all,
  output logic [N_CH-1:0]    above,
  output logic               scan_done
);

  localparam int DATA_W   = 12;
  localparam int HALF_RAW = CLK_HZ / (2 * SCLK_HZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int HCW      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PCW      = $clog2(CYCLE_PAUSE + 1);

  typedef enum logic [1:0] {IDLE, FRAME, UPDATE, PAUSE} state_t;

  state_t            state;
  logic [HCW-1:0]    hcnt;
  logic [3:0]        bcnt;
  logic [PCW-1:0]    pcnt;
  logic [2:0]        cur_ch;
  logic [2:0]        frame_ch;
  logic              prev_valid;
  logic [N_CH-1:0]   mask_q;
  logic [14:0]       din_sh;
  logic [DATA_W-1:0] rx;
  logic [2:0]        nxt_ch;
  logic              start;

  // Nearest set bit strictly after cur, wrapping; a lone enabled channel returns itself.
  function automatic logic [2:0] next_after(input logic [2:0] cur, input logic [N_CH-1:0] m);
    logic [2:0] r;
    int best;
    int d;
    r    = cur;
    best = N_CH + 1;
    for (int i = 0; i < N_CH; i++) begin
      d = (i - int'(cur) + N_CH) % N_CH;
      if (d == 0) d = N_CH;
      if (m[i] && d < best) begin
        best = d;
        r    = 3'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] top_ch(input logic [N_CH-1:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

  // High threshold checked first so an inverted threshold pair still resolves.
  function automatic logic hyst(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] hi,
                                input logic [DATA_W-1:0] lo, input logic cur);
    if (d >= hi) return 1'b1;
    if (d <= lo) return 1'b0;
    return cur;
  endfunction

  assign nxt_ch = next_after(cur_ch, ch_mask);
  assign start  = en && (ch_mask != '0) &&
                  ((state == IDLE) || (state == PAUSE && pcnt == PCW'(CYCLE_PAUSE)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      spi_csn      <= 1'b1;
      spi_sclk     <= 1'b1;
      spi_mosi     <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      data_all     <= '0;
      above        <= '0;
      scan_done    <= 1'b0;
      prev_valid   <= 1'b0;
      cur_ch       <= '0;
      hcnt         <= '0;
      bcnt         <= '0;
      pcnt         <= '0;
    end else begin
      sample_valid <= 1'b0;
      scan_done    <= 1'b0;
      if (start) begin
        state    <= FRAME;
        spi_csn  <= 1'b0;
        spi_sclk <= 1'b0;
        spi_mosi <= 1'b0;
        din_sh   <= {1'b0, nxt_ch, 11'b0};
        mask_q   <= ch_mask;
        frame_ch <= nxt_ch;
        hcnt     <= '0;
        bcnt     <= '0;
      end else begin
        case (state)
          IDLE: prev_valid <= 1'b0;
          FRAME: begin
            if (hcnt != HCW'(HALF - 1)) begin
              hcnt <= hcnt + 1'b1;
            end else begin
              hcnt <= '0;
              if (!spi_sclk) begin
                spi_sclk <= 1'b1;
                rx       <= {rx[DATA_W-2:0], spi_miso};
                if (bcnt == 4'd15) state <= UPDATE;
              end else begin
                spi_sclk <= 1'b0;
                spi_mosi <= din_sh[14];
                din_sh   <= {din_sh[13:0], 1'b0};
                bcnt     <= bcnt + 1'b1;
              end
            end
          end
          // Publish stage: the captured word belongs to the channel addressed last frame.
          UPDATE: begin
            spi_csn <= 1'b1;
            pcnt    <= '0;
            state   <= PAUSE;
            if (prev_valid) begin
              sample_valid <= 1'b1;
              sample_ch    <= cur_ch;
              sample_data  <= rx;
              scan_done    <= (cur_ch == top_ch(mask_q));
              for (int i = 0; i < N_CH; i++) begin
                if (cur_ch == 3'(i)) begin
                  data_all[12*i +: 12] <= rx;
                  above[i] <= hyst(rx, th_high[12*i +: 12], th_low[12*i +: 12], above[i]);
                end
              end
            end
            prev_valid <= 1'b1;
            cur_ch     <= frame_ch;
          end
          PAUSE: begin
            if (pcnt == PCW'(CYCLE_PAUSE)) begin
              state      <= IDLE;
              prev_valid <= 1'b0;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
